tone_synth: RTL and testbench
=============================

// Module: tone_synth
// PURPOSE
//  Transmit side of the tone path: converts a 3-bit tone identifier into a fixed-length
//  burst of 8-bit signed audio at the 12 kHz sample rate.
//  Its stream has the same format as the microphone samples fed to recorder (8-bit signed,
//  one valid per sample tick).
//  Drives the speaker/PWM path. In loopback it feeds recorder -> FFT -> tone_detection_fsm,
//  so every detector tone can be generated on chip.
// PARAMETERS
//  DUR_SAMPLES  6000  samples per burst (0.5 s at 12 kHz); legal range 1..65535
//  PHASE_W      16    phase accumulator width; top 8 bits address the sine
// PORTS
//  clk_in          in   1  system clock (100 MHz)
//  rst_in          in   1  synchronous, active-high reset
//  sample_tick_in  in   1  one-cycle 12 kHz sample strobe
//  tone_valid_in   in   1  request valid
//  tone_ident_in   in   3  0..6 = C4,D4,E4,F4,G4,A4,B4; 7 = rest (silence)
//  tone_ready_out  out  1  high in IDLE; request accepted on valid&&ready
//  audio_out       out  8  signed sample, held between valids
//  audio_valid_out out  1  one-cycle pulse per emitted sample
//  busy_out        out  1  high while a burst is playing
//  done_out        out  1  one-cycle pulse after the last sample of a burst
// BEHAVIOUR
//  Reset: state=IDLE, phase=0, count=0, audio_out=0, audio_valid_out=0, done_out=0,
//   busy_out=0, tone_ready_out=1. Reset mid-burst aborts the burst immediately; no done_out.
//  Increment table: inc = round(f*2^16/12000).
//   0:1431, 1:1606, 2:1802, 3:1906, 4:2141, 5:2403, 6:2698, 7:0.
//  FSM IDLE: tone_ready_out=1. On tone_valid_in&&tone_ready_out, latch the ident into inc_r,
//   clear phase and count, go to PLAY. tone_ready_out drops the next cycle.
//  FSM PLAY: tone_ready_out=0, busy_out=1, tone_valid_in ignored. On each sample_tick_in:
//   - compute sample from current phase; register it; audio_out/audio_valid_out update 1 cycle
//     after the tick
//   - phase <= phase + inc_r; wraps modulo 2^PHASE_W
//   - count <= count + 1
//   On the tick where count == DUR_SAMPLES-1 (last sample):
//   - go to IDLE; done_out pulses together with the last audio_valid_out
//   - tone_ready_out=1 on that same cycle
//  Ticks in IDLE produce no output. A tick coinciding with acceptance is not consumed;
//   the first sample comes from the next tick.
//  Sine: p = phase[PHASE_W-1 -: 8]; q = p[7:6]; i = p[5:0].
//   LUT[i] = round(127*sin(pi/2*i/64)), 64 x 7 bits, unsigned; LUT[0]=0, LUT[63]=127.
//   q0: +LUT[i]   q1: +LUT[63-i]   q2: -LUT[i]   q3: -LUT[63-i]   (two's complement, 8 bit)
//  Rest (ident 7): inc=0 and audio_out forced to 0.
//   Burst timing, valids and done_out are identical to a tone.
//  Output range -127..+127; -128 is never produced.
// TESTING
//  1 Reset, then ident=5, DUR_SAMPLES=8, tick every 10 clocks.
//    -> audio_out sequence 0, 28, 54, ...; 8 valids; done_out on the 8th; ready high after.
//  2 ident=7, DUR_SAMPLES=8 -> 8 valid pulses, all audio_out=0, done_out once.
//  3 Request during PLAY (valid held).
//    -> ignored until the done_out cycle; the next burst is accepted at the first ready cycle.
//  4 rst_in asserted at sample 3 of a burst.
//    -> next cycle IDLE, audio_out=0, no done_out, ready=1.
//  5 ident=6 with the default DUR_SAMPLES, tones compared against a golden model.
//    -> exact match over 6000 samples, including phase wrap (q3 to q0).
//    -> sign symmetry: q2 sample equals minus the matching q0 sample.
//  6 Loopback: audio_out -> recorder -> FFT -> tone_detection_fsm for idents 0..6.
//    -> detected tone_ident equals the requested ident.

Source files
------------

// File: rtl/tone_synth.sv
// Tone burst generator: turns a 3-bit tone identifier into a fixed-length burst of
// 8-bit signed sine samples, one per sample tick, with a done pulse on the last one.
module tone_synth #(
    parameter int unsigned DUR_SAMPLES = 6000,
    parameter int unsigned PHASE_W     = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       sample_tick_in,
    input  logic       tone_valid_in,
    input  logic [2:0] tone_ident_in,
    output logic       tone_ready_out,
    output logic [7:0] audio_out,
    output logic       audio_valid_out,
    output logic       busy_out,
    output logic       done_out
);

    // state | meaning
    // IDLE  | waiting for a request, ready high, ticks ignored
    // PLAY  | emitting one sample per tick until the burst length is reached
    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(DUR_SAMPLES - 1);

    // Quarter-wave table: round(127*sin(pi/2*i/64)) for i = 0..63.
    localparam logic [6:0] SINE_LUT [64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

    // Phase increment per sample: round(f * 2^16 / 12000); ident 7 is a rest.
    function automatic logic [15:0] inc_lookup(input logic [2:0] ident);
        logic [15:0] inc;
        case (ident)
            3'd0:    inc = 16'd1431;
            3'd1:    inc = 16'd1606;
            3'd2:    inc = 16'd1802;
            3'd3:    inc = 16'd1906;
            3'd4:    inc = 16'd2141;
            3'd5:    inc = 16'd2403;
            3'd6:    inc = 16'd2698;
            default: inc = 16'd0;
        endcase
        return inc;
    endfunction

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   inc_q,   inc_d;
    logic [15:0]          count_q, count_d;
    logic                 rest_q,  rest_d;
    logic [7:0]           audio_q, audio_d;
    logic                 valid_q, valid_d;
    logic                 done_q,  done_d;

    logic [7:0]           phase_top;
    logic [5:0]           lut_idx;
    logic [6:0]           lut_mag;
    logic [7:0]           sine_val;

    // Quadrants 1 and 3 read the table mirrored; 63-i equals the bitwise inverse of i.
    assign phase_top = phase_q[PHASE_W-1 -: 8];
    assign lut_idx   = phase_top[6] ? ~phase_top[5:0] : phase_top[5:0];
    assign lut_mag   = SINE_LUT[lut_idx];
    assign sine_val  = phase_top[7] ? (8'd0 - {1'b0, lut_mag}) : {1'b0, lut_mag};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        count_d = count_q;
        rest_d  = rest_q;
        audio_d = audio_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tone_valid_in) begin
                    inc_d   = PHASE_W'(inc_lookup(tone_ident_in));
                    rest_d  = (tone_ident_in == 3'd7);
                    phase_d = '0;
                    count_d = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (sample_tick_in) begin
                    audio_d = rest_q ? 8'd0 : sine_val;
                    valid_d = 1'b1;
                    phase_d = phase_q + inc_q;
                    count_d = count_q + 16'd1;
                    if (count_q == LAST_COUNT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            inc_q   <= '0;
            count_q <= '0;
            rest_q  <= 1'b0;
            audio_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            count_q <= count_d;
            rest_q  <= rest_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign tone_ready_out  = (state_q == S_IDLE);
    assign busy_out        = (state_q == S_PLAY);
    assign audio_out       = audio_q;
    assign audio_valid_out = valid_q;
    assign done_out        = done_q;

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: a short-burst instance for table, random and corner sequences,
// and a default-length instance compared sample by sample against a sine reference.
module tb_tone_synth;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Short-burst instance
    logic       rst_a, tvalid_a, tick_a, gen_tick_a, man_tick_a;
    logic [2:0] tid_a;
    logic       ready_a, aval_a, busy_a, done_a;
    logic [7:0] audio_a;
    int         period_a = 0;
    int         cnt_a    = 0;

    // Default-length instance
    logic       rst_b, tvalid_b, tick_b;
    logic [2:0] tid_b;
    logic       ready_b, aval_b, busy_b, done_b;
    logic [7:0] audio_b;
    int         cnt_b    = 0;

    assign tick_a = gen_tick_a | man_tick_a;

    tone_synth #(.DUR_SAMPLES(8)) dut_a (
        .clk_in(clk), .rst_in(rst_a), .sample_tick_in(tick_a),
        .tone_valid_in(tvalid_a), .tone_ident_in(tid_a),
        .tone_ready_out(ready_a), .audio_out(audio_a), .audio_valid_out(aval_a),
        .busy_out(busy_a), .done_out(done_a)
    );

    tone_synth dut_b (
        .clk_in(clk), .rst_in(rst_b), .sample_tick_in(tick_b),
        .tone_valid_in(tvalid_b), .tone_ident_in(tid_b),
        .tone_ready_out(ready_b), .audio_out(audio_b), .audio_valid_out(aval_b),
        .busy_out(busy_b), .done_out(done_b)
    );

    typedef struct {
        int audio;
        bit done;
        bit ready;
        bit busy;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  done_cnt_a = 0, done_cnt_b = 0, orphan_a = 0, orphan_b = 0;

    int inc_tab[8] = '{1431, 1606, 1802, 1906, 2141, 2403, 2698, 0};

    typedef struct {
        int ident;
        int period;
        int e0, e1, e2, e3;
    } vec_t;
    vec_t tbl[6];

    // Reference: sine evaluated directly from its definition.
    function automatic int lut_ref(input int i);
        real v;
        v = 127.0 * $sin(3.141592653589793 * i / 128.0);
        return $rtoi(v + 0.5);
    endfunction

    function automatic int model_phase(input int ph);
        int p, qd, i;
        p  = ph / 256;
        qd = p / 64;
        i  = p % 64;
        case (qd)
            0:       return lut_ref(i);
            1:       return lut_ref(63 - i);
            2:       return -lut_ref(i);
            default: return -lut_ref(63 - i);
        endcase
    endfunction

    function automatic int model_sample(input int ident, input int k);
        if (ident == 7) return 0;
        return model_phase((k * inc_tab[ident]) % 65536);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Free-running tick generators
    initial begin
        gen_tick_a = 1'b0;
        forever begin
            @(negedge clk);
            if (period_a == 0) begin
                gen_tick_a = 1'b0;
                cnt_a = 0;
            end else if (cnt_a >= period_a - 1) begin
                gen_tick_a = 1'b1;
                cnt_a = 0;
            end else begin
                gen_tick_a = 1'b0;
                cnt_a++;
            end
        end
    end

    initial begin
        tick_b = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt_b >= 2) begin
                tick_b = 1'b1;
                cnt_b = 0;
            end else begin
                tick_b = 1'b0;
                cnt_b++;
            end
        end
    end

    // Output monitors
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                if (aval_a) q_a.push_back('{int'($signed(audio_a)), done_a, ready_a, busy_a});
                if (done_a) done_cnt_a++;
                if (done_a && !aval_a) orphan_a++;
            end
            if (!rst_b) begin
                if (aval_b) q_b.push_back('{int'($signed(audio_b)), done_b, ready_b, busy_b});
                if (done_b) done_cnt_b++;
                if (done_b && !aval_b) orphan_b++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready_a(input string tag);
        int c = 0;
        while (!ready_a && c < 2000) begin step(); c++; end
        check({tag, " ready_wait"}, int'(ready_a), 1);
    endtask

    task automatic start_a(input string tag, input int ident);
        wait_ready_a(tag);
        q_a.delete();
        done_cnt_a = 0;
        tvalid_a = 1'b1;
        tid_a = 3'(ident);
        step();
        tvalid_a = 1'b0;
        check({tag, " accept_busy"}, int'(busy_a), 1);
    endtask

    task automatic collect_a(input string tag, input int budget);
        int c = 0;
        while (done_cnt_a == 0 && c < budget) begin step(); c++; end
        check({tag, " finished"}, int'(done_cnt_a > 0), 1);
    endtask

    task automatic verify_a(input string tag, input int ident, input int n);
        check({tag, " count"}, q_a.size(), n);
        check({tag, " done_cnt"}, done_cnt_a, 1);
        for (int k = 0; k < q_a.size() && k < n; k++) begin
            check($sformatf("%s s%0d", tag, k), q_a[k].audio, model_sample(ident, k));
            check($sformatf("%s done%0d", tag, k), int'(q_a[k].done), (k == n - 1) ? 1 : 0);
        end
        if (q_a.size() >= n) begin
            check({tag, " ready_at_done"}, int'(q_a[n-1].ready), 1);
            check({tag, " busy_at_done"}, int'(q_a[n-1].busy), 0);
        end
    endtask

    initial begin
        int n_ok;
        int c;
        rst_a = 1'b1; tvalid_a = 1'b0; tid_a = 3'd0; man_tick_a = 1'b0;
        rst_b = 1'b1; tvalid_b = 1'b0; tid_b = 3'd0;

        tbl[0] = '{5, 10, 0, 28, 54, 81};
        tbl[1] = '{7, 10, 0, 0, 0, 0};
        tbl[2] = '{0, 4, 0, 16, 34, 49};
        tbl[3] = '{1, 7, 0, 19, 37, 54};
        tbl[4] = '{3, 2, 0, 22, 43, 65};
        tbl[5] = '{6, 13, 0, 31, 63, 88};

        repeat (3) step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        check("reset ready", int'(ready_a), 1);
        check("reset audio", int'(audio_a), 0);
        check("reset valid", int'(aval_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset ready_b", int'(ready_b), 1);

        // Table-driven bursts
        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            period_a = tbl[i].period;
            start_a(tag, tbl[i].ident);
            collect_a(tag, 8 * tbl[i].period + 50);
            repeat (2 * tbl[i].period) step();
            verify_a(tag, tbl[i].ident, 8);
            if (q_a.size() >= 4) begin
                check({tag, " e0"}, q_a[0].audio, tbl[i].e0);
                check({tag, " e1"}, q_a[1].audio, tbl[i].e1);
                check({tag, " e2"}, q_a[2].audio, tbl[i].e2);
                check({tag, " e3"}, q_a[3].audio, tbl[i].e3);
            end
        end

        // Tick coinciding with acceptance is not consumed; one-cycle output latency
        period_a = 0;
        repeat (3) step();
        wait_ready_a("coinc");
        q_a.delete();
        done_cnt_a = 0;
        tvalid_a = 1'b1; tid_a = 3'd4; man_tick_a = 1'b1;
        step();
        tvalid_a = 1'b0; man_tick_a = 1'b0;
        check("coinc busy", int'(busy_a), 1);
        check("coinc no_valid", int'(aval_a), 0);
        for (int k = 0; k < 8; k++) begin
            repeat (2) step();
            man_tick_a = 1'b1;
            step();
            man_tick_a = 1'b0;
            check($sformatf("coinc valid%0d", k), int'(aval_a), 1);
            check($sformatf("coinc s%0d", k), int'($signed(audio_a)), model_sample(4, k));
            check($sformatf("coinc done%0d", k), int'(done_a), (k == 7) ? 1 : 0);
        end
        step();
        check("coinc held_audio", int'($signed(audio_a)), model_sample(4, 7));
        for (int k = 0; k < 3; k++) begin
            man_tick_a = 1'b1;
            step();
            man_tick_a = 1'b0;
            step();
        end
        check("idle_ticks no_output", q_a.size(), 8);

        // Request held during PLAY: ignored until the done cycle, then accepted
        period_a = 5;
        wait_ready_a("hold");
        q_a.delete();
        done_cnt_a = 0;
        tvalid_a = 1'b1; tid_a = 3'd2;
        step();
        check("hold busy", int'(busy_a), 1);
        tid_a = 3'd4;
        collect_a("hold", 8 * 5 + 50);
        check("hold ready_at_done", int'(ready_a), 1);
        verify_a("hold1", 2, 8);
        q_a.delete();
        done_cnt_a = 0;
        step();
        tvalid_a = 1'b0;
        check("hold second_busy", int'(busy_a), 1);
        check("hold second_not_ready", int'(ready_a), 0);
        collect_a("hold2", 8 * 5 + 50);
        repeat (10) step();
        verify_a("hold2", 4, 8);

        // Reset mid-burst
        period_a = 6;
        start_a("rst", 3);
        c = 0;
        while (q_a.size() < 3 && c < 200) begin step(); c++; end
        check("rst reached_s3", q_a.size(), 3);
        rst_a = 1'b1;
        step();
        check("rst busy", int'(busy_a), 0);
        check("rst ready", int'(ready_a), 1);
        check("rst audio", int'(audio_a), 0);
        check("rst valid", int'(aval_a), 0);
        check("rst done", int'(done_a), 0);
        rst_a = 1'b0;
        repeat (20 * 6) step();
        check("rst no_more_samples", q_a.size(), 3);
        check("rst no_done", done_cnt_a, 0);

        // Randomized bursts
        for (int r = 0; r < 15; r++) begin
            int ident;
            string tag;
            ident = int'($urandom_range(0, 7));
            period_a = int'($urandom_range(2, 12));
            repeat ($urandom_range(0, 5)) step();
            tag = $sformatf("rnd%0d_id%0d", r, ident);
            start_a(tag, ident);
            collect_a(tag, 8 * period_a + 50);
            repeat (2 * period_a) step();
            verify_a(tag, ident, 8);
        end
        check("done_without_valid_a", orphan_a, 0);

        // Full-length burst on the default instance
        c = 0;
        while (!ready_b && c < 100) begin step(); c++; end
        q_b.delete();
        done_cnt_b = 0;
        tvalid_b = 1'b1; tid_b = 3'd6;
        step();
        tvalid_b = 1'b0;
        check("long busy", int'(busy_b), 1);
        c = 0;
        while (done_cnt_b == 0 && c < 6000 * 3 + 200) begin step(); c++; end
        check("long finished", int'(done_cnt_b > 0), 1);
        repeat (10) step();
        check("long count", q_b.size(), 6000);
        check("long done_cnt", done_cnt_b, 1);
        n_ok = 0;
        for (int k = 0; k < q_b.size() && k < 6000; k++) begin
            int ph;
            ph = (k * 2698) % 65536;
            check($sformatf("long s%0d", k), q_b[k].audio, model_sample(6, k));
            check($sformatf("long done%0d", k), int'(q_b[k].done), (k == 5999) ? 1 : 0);
            if (ph / 16384 == 2) begin
                check($sformatf("long sym%0d", k), q_b[k].audio, -model_phase(ph - 32768));
                n_ok++;
            end
        end
        check("long sym_seen", int'(n_ok > 0), 1);
        check("long ready_after", int'(ready_b), 1);
        check("done_without_valid_b", orphan_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
